// File: rtl/window_conv_sequencer.sv
// window_conv_sequencer: drives the shift enable of a 3x3 line-buffered
// convolution window from a raster pixel stream and tags each result.
// Ports: clk, reset (sync, active-high); in_valid/in_sof/in_ready pixel
// handshake; shift_en/pad_zero to the window datapath; out_valid, out_col,
// out_row, out_border, conv_mask, frame_done aligned with the conv result;
// busy (not idle) and sync_err (unexpected start of frame).
// Optional macro WINDOW_BORDER_MASK_EN: conv_mask follows out_border so the
// datapath zeroes border results; otherwise conv_mask is tied low.
module window_conv_sequencer #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CONV_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic       shift_en,
  output logic       pad_zero,
  output logic       out_valid,
  output logic [9:0] out_col,
  output logic [8:0] out_row,
  output logic       out_border,
  output logic       conv_mask,
  output logic       frame_done,
  output logic       busy,
  output logic       sync_err
);

  localparam int TOTAL = IMG_W * IMG_H;
  localparam int CW    = $clog2(TOTAL + IMG_W + 2);
  localparam int PW    = 22;

  // shift count at which the last source pixel enters
  localparam logic [CW-1:0] N_TOTAL =
    CW'(TOTAL);
  // shift count of the final flush cycle
  localparam logic [CW-1:0] N_LAST =
    CW'(TOTAL + IMG_W + 1);
  // shifts needed before the window centre holds pixel (0,0)
  localparam logic [CW-1:0] N_PRIME =
    CW'(IMG_W + 1);

  localparam logic [9:0] COL_LAST = 10'(IMG_W - 1);
  localparam logic [8:0] ROW_LAST = 9'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] shift_cnt;
  logic [CW-1:0] cnt_nx;
  logic [CW-1:0] n;

  logic [9:0] ccol;
  logic [8:0] crow;

  logic restart;
  logic gen;
  logic border;
  logic last_ctr;

  logic [PW-1:0] stage_in;
  logic [PW-1:0] pipe [CONV_LAT];

  // Next-state and per-cycle controls
  always_comb begin
    state_nx = state;
    cnt_nx   = shift_cnt;
    n        = shift_cnt;
    in_ready = 1'b0;
    shift_en = 1'b0;
    pad_zero = 1'b0;
    busy     = 1'b0;
    sync_err = 1'b0;
    restart  = 1'b0;

    if (reset) begin
      in_ready = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready = 1'b1;
          if (in_valid && in_sof) begin
            shift_en = 1'b1;
            restart  = 1'b1;
            n        = CW'(1);
            cnt_nx   = n;
            state_nx = RUN;
          end
        end

        RUN: begin
          in_ready = 1'b1;
          busy     = 1'b1;
          if (in_valid) begin
            shift_en = 1'b1;
            if (in_sof) begin
              // resync: this pixel becomes a new (0,0)
              sync_err = (shift_cnt != '0);
              restart  = 1'b1;
              n        = CW'(1);
              cnt_nx   = n;
            end else begin
              n      = shift_cnt + CW'(1);
              cnt_nx = n;
              if (n == N_TOTAL) begin
                state_nx = FLUSH;
              end
            end
          end
        end

        FLUSH: begin
          busy     = 1'b1;
          pad_zero = 1'b1;
          shift_en = 1'b1;
          n        = shift_cnt + CW'(1);
          cnt_nx   = n;
          if (n == N_LAST) begin
            cnt_nx   = '0;
            state_nx = IDLE;
          end
        end

        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // A shift past the priming depth places a new centre in the window.
  assign gen = shift_en && (n > N_PRIME);

  assign border = (crow == 9'd0) ||
                  (crow == ROW_LAST) ||
                  (ccol == 10'd0) ||
                  (ccol == COL_LAST);

  assign last_ctr = (ccol == COL_LAST) &&
                    (crow == ROW_LAST);

  // Bubbles enter the pipe as all-zero entries.
  assign stage_in = gen ?
    {1'b1, border, last_ctr, ccol, crow} :
    '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_cnt <= '0;
      ccol      <= '0;
      crow      <= '0;
      for (int i = 0; i < CONV_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      state     <= state_nx;
      shift_cnt <= cnt_nx;

      if (restart) begin
        ccol <= '0;
        crow <= '0;
      end else if (gen) begin
        if (ccol == COL_LAST) begin
          ccol <= '0;
          if (crow == ROW_LAST) begin
            crow <= '0;
          end else begin
            crow <= crow + 9'd1;
          end
        end else begin
          ccol <= ccol + 10'd1;
        end
      end

      pipe[0] <= stage_in;
      for (int i = 1; i < CONV_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign {out_valid,
          out_border,
          frame_done,
          out_col,
          out_row} = pipe[CONV_LAT-1];

`ifdef WINDOW_BORDER_MASK_EN
  assign conv_mask = out_border;
`else
  assign conv_mask = 1'b0;
`endif

endmodule

// File: tb/tb_window_conv_sequencer.sv
// tb_window_conv_sequencer: self-checking bench for window_conv_sequencer
// on a 4x3 image against a frame-level reference model.
module tb_window_conv_sequencer;

  localparam int W = 4;
  localparam int H = 3;
  localparam int LAT = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic       in_ready;
  logic       shift_en;
  logic       pad_zero;
  logic       out_valid;
  logic [9:0] out_col;
  logic [8:0] out_row;
  logic       out_border;
  logic       conv_mask;
  logic       frame_done;
  logic       busy;
  logic       sync_err;

  window_conv_sequencer #(
    .IMG_W(W),
    .IMG_H(H),
    .CONV_LAT(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_sof(in_sof),
    .in_ready(in_ready),
    .shift_en(shift_en),
    .pad_zero(pad_zero),
    .out_valid(out_valid),
    .out_col(out_col),
    .out_row(out_row),
    .out_border(out_border),
    .conv_mask(conv_mask),
    .frame_done(frame_done),
    .busy(busy),
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: frame shift count, in-frame flag, flush cycles
  // remaining, and the centre index whose result appears next cycle.
  int m_k = 0;
  bit m_run = 0;
  int m_flush = 0;
  bit p_v = 0;
  int p_idx = 0;

  logic [27:0] ov;
  logic [27:0] ev;

  function automatic logic [27:0] obs_vec();
    return {in_ready, shift_en, pad_zero, busy, sync_err,
            out_valid, frame_done,
            out_valid ?
              {out_border, conv_mask, out_row, out_col} :
              21'h0};
  endfunction

  task automatic model_clear();
    m_k = 0;
    m_run = 0;
    m_flush = 0;
    p_v = 0;
    p_idx = 0;
  endtask

  // Drive one cycle, sample the DUT and compute the model's expectation.
  task automatic step(input bit v, input bit sof);
    logic e_ready, e_shift, e_pad, e_busy, e_sync;
    logic e_valid, e_done, e_border, e_mask;
    logic [9:0] e_col;
    logic [8:0] e_row;
    int r, c;
    @(negedge clk);
    in_valid = v;
    in_sof = sof;
    #1;
    ov = obs_vec();
    r = p_idx / W;
    c = p_idx % W;
    e_valid = p_v;
    e_row = 9'(r);
    e_col = 10'(c);
    e_border = (r == 0) || (r == H - 1) ||
               (c == 0) || (c == W - 1);
    e_done = p_v && (p_idx == W * H - 1);
`ifdef WINDOW_BORDER_MASK_EN
    e_mask = e_border;
`else
    e_mask = 1'b0;
`endif
    e_ready = (m_flush == 0);
    e_pad = (m_flush > 0);
    e_busy = m_run || (m_flush > 0);
    e_sync = 1'b0;
    e_shift = 1'b0;
    p_v = 0;
    if (m_flush > 0) begin
      e_shift = 1'b1;
      m_k++;
      m_flush--;
    end else if (v && sof) begin
      e_shift = 1'b1;
      e_sync = m_run;
      m_k = 1;
      m_run = 1;
    end else if (v && m_run) begin
      e_shift = 1'b1;
      m_k++;
      if (m_k == W * H) begin
        m_run = 0;
        m_flush = W + 1;
      end
    end
    if (e_shift && m_k >= W + 2) begin
      p_v = 1;
      p_idx = m_k - (W + 2);
    end
    ev = {e_ready, e_shift, e_pad, e_busy, e_sync,
          e_valid, e_done,
          e_valid ? {e_border, e_mask, e_row, e_col} : 21'h0};
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    in_sof = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_sof = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ov = obs_vec();
    n_checks++;
    if (ov !== {1'b1, 27'h0})
      $display("FAIL reset_hold got %h want %h", ov, {1'b1, 27'h0});
    else n_pass++;
    reset = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      n_checks++;
      if (ov !== ev)
        $display("FAIL reset_idle c%0d got %h want %h", i, ov, ev);
      else n_pass++;
    end
  endtask

  task automatic test_frame();
    int nshift = 0, nrdy = 0, nval = 0, nb0 = 0;
    int ndone = 0, first = -1, cyc = 0;
    for (int i = 0; i < W * H + 8; i++) begin
      step(i < W * H, i == 0);
      n_checks++;
      if (ov !== ev)
        $display("FAIL frame c%0d got %h want %h", i, ov, ev);
      else n_pass++;
      nshift += int'(shift_en);
      nrdy += int'(!in_ready);
      if (out_valid) begin
        nval++;
        if (first < 0) first = cyc;
        if (!out_border) nb0++;
      end
      ndone += int'(frame_done);
      cyc++;
    end
    n_checks++;
    if (nshift != W * H + W + 1)
      $display("FAIL frame_shifts got %0d want %0d", nshift, W * H + W + 1);
    else n_pass++;
    n_checks++;
    if (nrdy != W + 1)
      $display("FAIL frame_ready_low got %0d want %0d", nrdy, W + 1);
    else n_pass++;
    n_checks++;
    if (first != W + 2)
      $display("FAIL frame_first_out got %0d want %0d", first, W + 2);
    else n_pass++;
    n_checks++;
    if (nval != W * H)
      $display("FAIL frame_outputs got %0d want %0d", nval, W * H);
    else n_pass++;
    n_checks++;
    if (nb0 != 2)
      $display("FAIL frame_inner got %0d want %0d", nb0, 2);
    else n_pass++;
    n_checks++;
    if (ndone != 1 || busy !== 1'b0)
      $display("FAIL frame_done got %0d/%b want 1/0", ndone, busy);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int nval = 0, nshift = 0, sent = 0;
    for (int i = 0; i < 2 * W * H + 8; i++) begin
      bit v;
      v = (i % 2 == 0) && (sent < W * H);
      step(v, v && sent == 0);
      if (v) sent++;
      n_checks++;
      if (ov !== ev)
        $display("FAIL gaps c%0d got %h want %h", i, ov, ev);
      else n_pass++;
      nval += int'(out_valid);
      nshift += int'(shift_en);
    end
    n_checks++;
    if (nval != W * H || nshift != W * H + W + 1)
      $display("FAIL gaps_counts got %0d/%0d want %0d/%0d",
               nval, nshift, W * H, W * H + W + 1);
    else n_pass++;
  endtask

  task automatic test_idle_nosof();
    int nshift = 0, nval = 0, nbusy = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), 0);
      n_checks++;
      if (ov !== ev)
        $display("FAIL idle c%0d got %h want %h", i, ov, ev);
      else n_pass++;
      nshift += int'(shift_en);
      nval += int'(out_valid);
      nbusy += int'(busy);
    end
    n_checks++;
    if (nshift + nval + nbusy != 0)
      $display("FAIL idle_activity got %0d want 0", nshift + nval + nbusy);
    else n_pass++;
  endtask

  task automatic test_sync_err();
    int nsync = 0, nval = 0;
    for (int i = 0; i < 6 + W * H + 8; i++) begin
      bit v;
      v = i < 6 + W * H;
      step(v, i == 0 || i == 6);
      n_checks++;
      if (ov !== ev)
        $display("FAIL sync c%0d got %h want %h", i, ov, ev);
      else n_pass++;
      nsync += int'(sync_err);
      nval += int'(out_valid);
    end
    n_checks++;
    if (nsync != 1 || nval != W * H + 1)
      $display("FAIL sync_counts got %0d/%0d want 1/%0d",
               nsync, nval, W * H + 1);
    else n_pass++;
  endtask

  task automatic test_reset_flush();
    int ndone = 0, nval = 0;
    for (int i = 0; i < W * H + 2; i++) begin
      step(i < W * H, i == 0);
      n_checks++;
      if (ov !== ev)
        $display("FAIL rflush_pre c%0d got %h want %h", i, ov, ev);
      else n_pass++;
    end
    do_reset(1);
    for (int i = 0; i < W + 2; i++) begin
      step(0, 0);
      n_checks++;
      if (ov !== ev)
        $display("FAIL rflush_post c%0d got %h want %h", i, ov, ev);
      else n_pass++;
      ndone += int'(frame_done);
    end
    n_checks++;
    if (ndone != 0)
      $display("FAIL rflush_no_done got %0d want 0", ndone);
    else n_pass++;
    ndone = 0;
    for (int i = 0; i < W * H + 8; i++) begin
      step(i < W * H, i == 0);
      n_checks++;
      if (ov !== ev)
        $display("FAIL rflush_next c%0d got %h want %h", i, ov, ev);
      else n_pass++;
      ndone += int'(frame_done);
      nval += int'(out_valid);
    end
    n_checks++;
    if (ndone != 1 || nval != W * H)
      $display("FAIL rflush_recover got %0d/%0d want 1/%0d",
               ndone, nval, W * H);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nmask = 0, nsync = 0, nidle = 0, ndone = 0;
    int exp_mask;
`ifdef WINDOW_BORDER_MASK_EN
    exp_mask = 2 * (W * H - 2);
`else
    exp_mask = 0;
`endif
    for (int i = 0; i < 2 * W * H + W + 2 + 8; i++) begin
      bit v, s;
      if (i < W * H) begin
        v = 1; s = (i == 0);
      end else if (i < W * H + W + 2) begin
        v = 1; s = 1;
      end else if (i < 2 * W * H + W + 1) begin
        v = 1; s = 0;
      end else begin
        v = 0; s = 0;
      end
      step(v, s);
      n_checks++;
      if (ov !== ev)
        $display("FAIL b2b c%0d got %h want %h", i, ov, ev);
      else n_pass++;
      nmask += int'(out_valid && conv_mask);
      nsync += int'(sync_err);
      ndone += int'(frame_done);
      if (i > 0 && i < 2 * W * H + W + 1)
        nidle += int'(!busy);
    end
    n_checks++;
    if (nsync != 0 || nidle != 1 || ndone != 2)
      $display("FAIL b2b_counts got %0d/%0d/%0d want 0/1/2",
               nsync, nidle, ndone);
    else n_pass++;
    n_checks++;
    if (nmask != exp_mask)
      $display("FAIL b2b_mask got %0d want %0d", nmask, exp_mask);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int sent = 0, guard = 0;
      repeat ($urandom_range(0, 3)) begin
        step(1'($urandom_range(0, 1)), 0);
        n_checks++;
        if (ov !== ev)
          $display("FAIL rand_pre f%0d got %h want %h", f, ov, ev);
        else n_pass++;
      end
      while (sent < W * H && guard < 300) begin
        bit v, s;
        v = ($urandom_range(0, 9) < 6);
        s = v && (sent == 0 || $urandom_range(0, 19) == 0);
        step(v, s);
        if (v) sent = s ? 1 : sent + 1;
        guard++;
        n_checks++;
        if (ov !== ev)
          $display("FAIL rand f%0d c%0d got %h want %h",
                   f, guard, ov, ev);
        else n_pass++;
      end
      n_checks++;
      if (sent != W * H)
        $display("FAIL rand_budget f%0d got %0d want %0d", f, sent, W * H);
      else n_pass++;
      for (int i = 0; i < W + 4; i++) begin
        step(0, 0);
        n_checks++;
        if (ov !== ev)
          $display("FAIL rand_tail f%0d c%0d got %h want %h",
                   f, i, ov, ev);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_gaps();
    test_idle_nosof();
    test_sync_err();
    test_reset_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window_conv_sequencer.md
Name: window_conv_sequencer

Overview:
- Controls the 3x3 line-buffered convolution window datapath (three-tap shift rows joined by two line FIFOs, IMG_W-3 deep).
- Accepts a raster pixel stream with valid/ready handshake and drives the window's shift enable.
- Tracks the raster position of the window centre and flushes the pipeline after the last pixel, so that exactly IMG_W*IMG_H output pixels carry a centre coordinate and a border flag.
- Sits between the camera/frame source and the window convolution.

Parameters:
- IMG_W, 640, pixels per line (>=4)
- IMG_H, 480, lines per frame (>=3)
- CONV_LAT, 1, clock cycles from a shift_en pulse to the convolution result being registered (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  source pixel valid
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0)
- in_ready  out  1  controller accepts pixel this cycle
- shift_en  out  1  advance window registers and line FIFOs one position
- pad_zero  out  1  datapath shifts in 12'h000 instead of the source pixel (flush)
- out_valid  out  1  convolution output corresponds to a centre pixel
- out_col  out  10  centre column, 0..IMG_W-1
- out_row  out  9  centre row, 0..IMG_H-1
- out_border  out  1  centre lies on first/last row or column
- conv_mask  out  1  datapath forces result to 0 (see Optional Feature)
- frame_done  out  1  one-cycle pulse with the final out_valid of a frame
- busy  out  1  state != IDLE
- sync_err  out  1  one-cycle pulse on an unexpected in_sof

Behaviour:
- Reset: state IDLE; all counters 0; delay pipe cleared; every output 0 except in_ready=1. Reset mid-frame abandons the frame, with no frame_done.
- States:
  - IDLE: in_ready=1. Pixels without in_sof are accepted and dropped, with shift_en=0. in_valid&in_sof gives shift_en=1, shift_cnt=1, and moves to RUN.
  - RUN: in_ready=1. Each in_valid gives shift_en=1 and shift_cnt+1. When the accepted pixel makes shift_cnt reach IMG_W*IMG_H, go to FLUSH.
  - FLUSH: in_ready=0, pad_zero=1, shift_en=1 every cycle, for IMG_W+1 cycles. Then return to IDLE.
- shift_cnt width: clog2(IMG_W*IMG_H+IMG_W+2) bits. It is never compared across a wrap.
- Centre tracking:
  - A shift producing total count n > IMG_W+1 sets a pending output for centre index n-(IMG_W+2).
  - The centre is held as separate ccol/crow counters. ccol wraps IMG_W-1 -> 0 and increments crow.
  - The first output is centre (0,0), on shift IMG_W+2.
  - Outputs per frame = IMG_W*IMG_H exactly.
- Latency: out_valid, out_col, out_row, out_border and conv_mask are delayed CONV_LAT cycles from the generating shift_en through a shift pipe. With no shift_en, the pipe still advances and inserts out_valid=0.
- out_border = (crow==0)|(crow==IMG_H-1)|(ccol==0)|(ccol==IMG_W-1).
- frame_done: asserted with the out_valid for centre (IMG_H-1, IMG_W-1).
- Stalls: in_valid=0 in RUN gives shift_en=0, and counters hold.
- Boundary cases:
  - in_sof in RUN with shift_cnt != 0: sync_err pulses. The pixel is accepted as a new (0,0), shift_cnt=1, and ccol/crow/pending outputs are cleared. Outputs already in the delay pipe complete.
  - in_sof during FLUSH: ignored, because in_ready=0.
  - in_sof on the same cycle FLUSH ends: not accepted, because in_ready=0 that cycle. It is accepted on the following IDLE cycle.
  - Back-to-back frames: IDLE lasts 1 cycle minimum.

Optional Feature:
- Macro: WINDOW_BORDER_MASK_EN.
- Defined: conv_mask = delayed out_border, so border outputs are forced to 0 by the datapath.
- Undefined: conv_mask is tied 0. out_border is still reported, and border outputs carry raw (wrapped/padded) results.

Test Plan:
- IMG_W=4, IMG_H=3, CONV_LAT=1; frame of 12 continuous pixels, sof on the first:
  - shift_en high 12+5 cycles; in_ready low for exactly 5 FLUSH cycles.
  - First out_valid 1 cycle after the 6th shift, centre (0,0), border=1.
  - 12 out_valid total; only (1,1) and (1,2) have border=0.
  - frame_done with (2,3); busy low afterwards.
- Same frame with in_valid low on every other cycle: identical output sequence; no shift_en during gaps; out_valid gaps match.
- Pixels without sof in IDLE: in_ready=1, shift_en=0, no outputs, busy=0.
- in_sof on the 7th pixel in RUN:
  - sync_err pulses once.
  - The pending centre (0,0) from the 6th shift still emits; no further outputs from the aborted frame.
  - The new frame then produces 12 outputs starting at (0,0).
- reset asserted for 1 cycle during FLUSH: next cycle all outputs 0, in_ready=1, no frame_done; the next sof frame completes normally.
- WINDOW_BORDER_MASK_EN defined vs undefined on the 4x3 frame: conv_mask equals out_border (10 masked) vs conv_mask always 0.
